conditional_sum_adder_pipe: RTL and testbench
=============================================

CONDITIONAL_SUM_ADDER_PIPE -- requirements
Module: conditional_sum_adder_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand/sum width; SHALL be a power of two, 4 to 64, with elaboration failing otherwise.
REQ-002 Derived constant L = log2(WIDTH) merge levels; LAT = L+1 pipeline register stages.
REQ-003 clk  input  1  rising-edge clock, sole clock domain.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 x  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 y  input  WIDTH  operand B.
REQ-009 c0  input  1  carry-in, used when sub=0.
REQ-010 sub  input  1  0 = add (x+y+c0), 1 = subtract (x+~y+1).
REQ-011 out_valid  output  1  result registers hold a valid result.
REQ-012 out_ready  input  1  consumer takes result this cycle.
REQ-013 sum  output  WIDTH  result bits [WIDTH-1:0].
REQ-014 cout  output  1  carry out of bit WIDTH-1.
REQ-015 ovf  output  1  signed overflow = carry into MSB XOR cout.

Function
REQ-016 Transfer in: operands accepted at a rising edge where in_valid && in_ready.
REQ-017 Transfer out: result consumed at a rising edge where out_valid && out_ready.
REQ-018 Advance enable adv = !out_valid || out_ready; all stages SHALL shift together only when adv=1.
REQ-019 in_ready SHALL equal adv combinationally, with no dependency on in_valid.
REQ-020 Stage 0 SHALL register, per bit i, conditional sum/carry pairs (s0,c0_i) and (s1,c1_i) assuming carry-in 0 and 1, plus the effective carry-in (sub ? 1 : c0); y SHALL be inverted first when sub=1.
REQ-021 Stage l (1..L) SHALL merge adjacent blocks of 2^(l-1) bits into blocks of 2^l bits, selecting the upper block's pair by the lower block's carry for each assumed carry-in, and register the result.
REQ-022 Bit 0 block SHALL resolve against the real effective carry-in at stage 1; no assumed-carry pair is needed for it afterward.
REQ-023 Stage L is the output register; sum, cout, ovf SHALL drive directly from it, with no combinational path from x/y to outputs.
REQ-024 Latency: with adv held 1, result of operands accepted at edge n SHALL appear with out_valid=1 after edge n+L (LAT edges counting acceptance); WIDTH=8 gives LAT=4.
REQ-025 Throughput: one result per cycle when out_ready stays 1.
REQ-026 Each stage SHALL carry a valid bit; bubbles SHALL propagate unchanged (no compaction).
REQ-027 Stall: while out_valid=1 and out_ready=0, sum/cout/ovf/out_valid and all stage contents SHALL hold, and in_ready=0.
REQ-028 Arithmetic SHALL be modulo 2^WIDTH; cout and ovf SHALL be per REQ-014/015 in both modes (no borrow inversion).
REQ-029 in_valid=0 at an adv edge SHALL inject a bubble; operand values SHALL then be don't-care.

Reset
REQ-030 rst_n=0 SHALL immediately clear all stage valid bits, out_valid=0, sum=0, cout=0, ovf=0, independent of clk.
REQ-031 in_ready SHALL read 1 during and after reset (out_valid=0).
REQ-032 Reset mid-operation SHALL discard every in-flight operand; no result from before reset SHALL ever appear.
REQ-033 First acceptance permitted at the first rising edge with rst_n=1.

Verification
REQ-034 WIDTH=8, out_ready=1: x=12,y=5,c0=0,sub=0 -> sum=17,cout=0,ovf=0 exactly 4 edges after acceptance; repeat c0=1 -> sum=18.
REQ-035 WIDTH=8: x=255,y=1,c0=0 -> sum=0,cout=1,ovf=0; x=127,y=1 -> sum=128,cout=0,ovf=1.
REQ-036 WIDTH=8, sub=1: x=5,y=12 -> sum=249,cout=0,ovf=0; x=12,y=5 -> sum=7,cout=1; x=128,y=1 -> sum=127,ovf=1.
REQ-037 Back-to-back stream of 20 random pairs with out_ready toggled pseudo-randomly -> all 20 results in order, none lost/duplicated, outputs stable during every stall, in_ready==adv every cycle.
REQ-038 Load 3 operand sets, assert rst_n=0 mid-cycle before any emerges -> out_valid=0 immediately, no stale result after release; next accepted 12+5 gives 17.
REQ-039 Repeat REQ-034/037 with WIDTH=4 and WIDTH=32 -> results match golden model, LAT=3 and 6 respectively.

Source files
------------

// File: rtl/conditional_sum_adder_pipe_if.sv
// Operand/result handshake bundle for conditional_sum_adder_pipe.
// slave is the adder's view; master is the producer/consumer side.
interface conditional_sum_adder_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             c0;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, x, y, c0, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, x, y, c0, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/conditional_sum_adder_pipe.sv
// Pipelined conditional-sum add/sub; log2(WIDTH)+1 cycle latency, one result per cycle.
// Whole pipe freezes while the output is held (out_valid && !out_ready); in_ready mirrors that.
module conditional_sum_adder_pipe #(
    parameter int WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    conditional_sum_adder_pipe_if.slave  bus
);
    localparam int L  = $clog2(WIDTH);
    localparam int HW = WIDTH / 2;

    if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("conditional_sum_adder_pipe: WIDTH must be a power of two in 4..64");
    end

    // s*/k* hold per-block sum/carry assuming block carry-in 0 (s0,k0) and 1 (s1,k1).
    // Block 0 is resolved from stage 1 on and only uses s0/k0.
    typedef struct packed {
        logic             vld;
        logic             cin;
        logic             pm;
        logic [WIDTH-1:0] s0;
        logic [WIDTH-1:0] s1;
        logic [WIDTH-1:0] k0;
        logic [WIDTH-1:0] k1;
    } stage_t;

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } res_t;

    res_t res_q;
    logic adv;

    assign adv          = !res_q.vld || bus.out_ready;
    assign bus.in_ready = adv;

    for (genvar l = 0; l < L; l++) begin : g_stg
        stage_t q;
        stage_t d;

        if (l == 0) begin : g_pre
            logic [WIDTH-1:0] yy;
            always_comb begin
                yy    = bus.sub ? ~bus.y : bus.y;
                d.vld = bus.in_valid;
                d.cin = bus.sub | bus.c0;
                d.pm  = bus.x[WIDTH-1] ^ yy[WIDTH-1];
                d.s0  = bus.x ^ yy;
                d.s1  = ~(bus.x ^ yy);
                d.k0  = bus.x & yy;
                d.k1  = bus.x | yy;
            end
        end else begin : g_merge
            localparam int B  = 1 << l;
            localparam int H  = B / 2;
            localparam int NB = WIDTH / B;
            stage_t         p;
            logic [H-1:0]   lo_s;
            logic           lo_c;

            assign p = g_stg[l-1].q;

            always_comb begin
                d     = '0;
                d.vld = p.vld;
                d.cin = p.cin;
                d.pm  = p.pm;
                // Bit-0 block gets resolved against the real carry-in on the first merge.
                lo_s  = p.s0[H-1:0];
                lo_c  = p.k0[0];
                if (l == 1 && p.cin) begin
                    lo_s = p.s1[H-1:0];
                    lo_c = p.k1[0];
                end
                d.s0[H-1:0]  = lo_s;
                d.s0[H +: H] = lo_c ? p.s1[H +: H] : p.s0[H +: H];
                d.k0[0]      = lo_c ? p.k1[1] : p.k0[1];
                for (int j = 1; j < NB; j++) begin
                    d.s0[j*B +: H]   = p.s0[j*B +: H];
                    d.s1[j*B +: H]   = p.s1[j*B +: H];
                    d.s0[j*B+H +: H] = p.k0[2*j] ? p.s1[j*B+H +: H] : p.s0[j*B+H +: H];
                    d.s1[j*B+H +: H] = p.k1[2*j] ? p.s1[j*B+H +: H] : p.s0[j*B+H +: H];
                    d.k0[j]          = p.k0[2*j] ? p.k1[2*j+1] : p.k0[2*j+1];
                    d.k1[j]          = p.k1[2*j] ? p.k1[2*j+1] : p.k0[2*j+1];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
            end else if (adv) begin
                q <= d;
            end
        end
    end

    stage_t           last;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;

    assign last = g_stg[L-1].q;

    always_comb begin
        sum_d  = {last.k0[0] ? last.s1[WIDTH-1:HW] : last.s0[WIDTH-1:HW], last.s0[HW-1:0]};
        cout_d = last.k0[0] ? last.k1[1] : last.k0[1];
    end

    // Carry into the MSB is recovered as sum_msb ^ x_msb ^ y_msb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else if (adv) begin
            res_q.vld  <= last.vld;
            res_q.sum  <= sum_d;
            res_q.cout <= cout_d;
            res_q.ovf  <= sum_d[WIDTH-1] ^ last.pm ^ cout_d;
        end
    end

    assign bus.out_valid = res_q.vld;
    assign bus.sum       = res_q.sum;
    assign bus.cout      = res_q.cout;
    assign bus.ovf       = res_q.ovf;
endmodule

// File: tb/tb_conditional_sum_adder_pipe.sv
// Bench for conditional_sum_adder_pipe at WIDTH 8, 4 and 32 side by side.
module tb_conditional_sum_adder_pipe;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    conditional_sum_adder_pipe_if #(.WIDTH(8))  bus8  ();
    conditional_sum_adder_pipe_if #(.WIDTH(4))  bus4  ();
    conditional_sum_adder_pipe_if #(.WIDTH(32)) bus32 ();

    conditional_sum_adder_pipe #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    conditional_sum_adder_pipe #(.WIDTH(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
    conditional_sum_adder_pipe #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    // index 0 = WIDTH 8, 1 = WIDTH 4, 2 = WIDTH 32
    logic        iv[3];
    logic        ordy[3];
    logic        c0d[3];
    logic        subd[3];
    logic [31:0] xd[3];
    logic [31:0] yd[3];
    logic        ir[3];
    logic        ov[3];
    logic        co[3];
    logic        of[3];
    logic [31:0] sm[3];

    assign bus8.in_valid  = iv[0];
    assign bus8.x         = xd[0][7:0];
    assign bus8.y         = yd[0][7:0];
    assign bus8.c0        = c0d[0];
    assign bus8.sub       = subd[0];
    assign bus8.out_ready = ordy[0];
    assign ir[0] = bus8.in_ready;
    assign ov[0] = bus8.out_valid;
    assign sm[0] = {24'd0, bus8.sum};
    assign co[0] = bus8.cout;
    assign of[0] = bus8.ovf;

    assign bus4.in_valid  = iv[1];
    assign bus4.x         = xd[1][3:0];
    assign bus4.y         = yd[1][3:0];
    assign bus4.c0        = c0d[1];
    assign bus4.sub       = subd[1];
    assign bus4.out_ready = ordy[1];
    assign ir[1] = bus4.in_ready;
    assign ov[1] = bus4.out_valid;
    assign sm[1] = {28'd0, bus4.sum};
    assign co[1] = bus4.cout;
    assign of[1] = bus4.ovf;

    assign bus32.in_valid  = iv[2];
    assign bus32.x         = xd[2];
    assign bus32.y         = yd[2];
    assign bus32.c0        = c0d[2];
    assign bus32.sub       = subd[2];
    assign bus32.out_ready = ordy[2];
    assign ir[2] = bus32.in_ready;
    assign ov[2] = bus32.out_valid;
    assign sm[2] = bus32.sum;
    assign co[2] = bus32.cout;
    assign of[2] = bus32.ovf;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic int width_of(int k);
        case (k)
            0:       width_of = 8;
            1:       width_of = 4;
            default: width_of = 32;
        endcase
    endfunction

    function automatic int lat_of(int k);
        lat_of = $clog2(width_of(k)) + 1;
    endfunction

    // Golden model: {ovf, cout, sum[31:0]} from plain wide arithmetic.
    function automatic logic [33:0] gold(int k, logic [31:0] a, logic [31:0] b, logic ci, logic s);
        int          w;
        logic [33:0] m, aa, bb, full, low;
        logic        cy, cmsb;
        w    = width_of(k);
        m    = (34'd1 << w) - 34'd1;
        aa   = {2'b00, a} & m;
        bb   = (s ? ~{2'b00, b} : {2'b00, b}) & m;
        full = aa + bb + {33'd0, s | ci};
        cy   = full[w];
        low  = (aa & (m >> 1)) + (bb & (m >> 1)) + {33'd0, s | ci};
        cmsb = low[w-1];
        gold = {cmsb ^ cy, cy, full[31:0] & m[31:0]};
    endfunction

    task automatic test_reset;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({ov[k], co[k], of[k], sm[k]} !== 35'd0) begin
                bad++;
                $display("FAIL reset_state dut%0d: valid=%b cout=%b ovf=%b sum=%0h required all 0",
                         k, ov[k], co[k], of[k], sm[k]);
            end
            total++;
            if (ir[k] !== 1'b1) begin
                bad++;
                $display("FAIL reset_in_ready dut%0d: got %b required 1", k, ir[k]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (ir[k] !== 1'b1 || ov[k] !== 1'b0) begin
                bad++;
                $display("FAIL post_reset dut%0d: in_ready=%b out_valid=%b required 1/0", k, ir[k], ov[k]);
            end
        end
    endtask

    typedef struct {
        int          k;
        logic [31:0] x;
        logic [31:0] y;
        logic        c0;
        logic        sub;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    task automatic test_directed;
        vec_t v[13];
        int   k;
        int   lat;
        v[0]  = '{0, 32'd12,  32'd5, 1'b0, 1'b0, 32'd17,  1'b0, 1'b0};
        v[1]  = '{0, 32'd12,  32'd5, 1'b1, 1'b0, 32'd18,  1'b0, 1'b0};
        v[2]  = '{0, 32'd255, 32'd1, 1'b0, 1'b0, 32'd0,   1'b1, 1'b0};
        v[3]  = '{0, 32'd127, 32'd1, 1'b0, 1'b0, 32'd128, 1'b0, 1'b1};
        v[4]  = '{0, 32'd5,   32'd12, 1'b0, 1'b1, 32'd249, 1'b0, 1'b0};
        v[5]  = '{0, 32'd12,  32'd5, 1'b0, 1'b1, 32'd7,   1'b1, 1'b0};
        v[6]  = '{0, 32'd128, 32'd1, 1'b0, 1'b1, 32'd127, 1'b1, 1'b1};
        v[7]  = '{1, 32'd12,  32'd5, 1'b0, 1'b0, 32'd1,   1'b1, 1'b0};
        v[8]  = '{1, 32'd7,   32'd1, 1'b0, 1'b0, 32'd8,   1'b0, 1'b1};
        v[9]  = '{1, 32'd3,   32'd5, 1'b0, 1'b1, 32'd14,  1'b0, 1'b0};
        v[10] = '{2, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0};
        v[11] = '{2, 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        v[12] = '{2, 32'd12,  32'd5, 1'b1, 1'b0, 32'd18,  1'b0, 1'b0};
        for (int i = 0; i < 13; i++) begin
            k   = v[i].k;
            lat = lat_of(k);
            @(negedge clk);
            xd[k] = v[i].x; yd[k] = v[i].y; c0d[k] = v[i].c0; subd[k] = v[i].sub;
            iv[k] = 1'b1;
            @(negedge clk);
            iv[k] = 1'b0;
            for (int e = 1; e < lat; e++) begin
                @(negedge clk);
                total++;
                if (ov[k] !== (e == lat - 1)) begin
                    bad++;
                    $display("FAIL latency row%0d edge+%0d: out_valid=%b required %b", i, e, ov[k], e == lat - 1);
                end
                if (e == lat - 1) begin
                    total++;
                    if (sm[k] !== v[i].s || co[k] !== v[i].co || of[k] !== v[i].ov) begin
                        bad++;
                        $display("FAIL result row%0d: sum=%0h cout=%b ovf=%b required sum=%0h cout=%b ovf=%b",
                                 i, sm[k], co[k], of[k], v[i].s, v[i].co, v[i].ov);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] px[20], py[20];
        logic        pc[20], ps[20];
        logic [33:0] exq[3][$];
        logic [33:0] held[3];
        logic [33:0] got, expv;
        logic        st[3];
        int          idx[3], rcv[3];
        int          cyc;
        bit          done;
        int          n;
        for (int i = 0; i < 20; i++) begin
            px[i] = $urandom; py[i] = $urandom;
            pc[i] = 1'($urandom_range(0, 1)); ps[i] = 1'($urandom_range(0, 1));
        end
        for (int k = 0; k < 3; k++) begin
            idx[k] = 0; rcv[k] = 0; st[k] = 1'b0; held[k] = '0;
        end
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 3; k++) begin
                if (st[k]) begin
                    total++;
                    if (ov[k] !== 1'b1 || {of[k], co[k], sm[k]} !== held[k]) begin
                        bad++;
                        $display("FAIL stall_hold dut%0d: valid=%b out=%0h required 1/%0h",
                                 k, ov[k], {of[k], co[k], sm[k]}, held[k]);
                    end
                end
                ordy[k] = ($urandom_range(0, 2) != 0);
                n       = (idx[k] < 20) ? idx[k] : 0;
                iv[k]   = (idx[k] < 20) && ($urandom_range(0, 3) != 0);
                xd[k] = px[n]; yd[k] = py[n]; c0d[k] = pc[n]; subd[k] = ps[n];
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                total++;
                if (ir[k] !== (!ov[k] || ordy[k])) begin
                    bad++;
                    $display("FAIL in_ready dut%0d: got %b required %b", k, ir[k], !ov[k] || ordy[k]);
                end
                if (ov[k] && ordy[k]) begin
                    total++;
                    got = {of[k], co[k], sm[k]};
                    if (exq[k].size() == 0) begin
                        bad++;
                        $display("FAIL extra_result dut%0d: got %0h required none", k, got);
                    end else begin
                        expv = exq[k].pop_front();
                        rcv[k]++;
                        if (got !== expv) begin
                            bad++;
                            $display("FAIL stream dut%0d #%0d: got %0h required %0h", k, rcv[k], got, expv);
                        end
                    end
                end
                st[k]   = ov[k] && !ordy[k];
                held[k] = {of[k], co[k], sm[k]};
                if (iv[k] && ir[k]) begin
                    exq[k].push_back(gold(k, xd[k], yd[k], c0d[k], subd[k]));
                    idx[k]++;
                end
            end
            done = (rcv[0] == 20) && (rcv[1] == 20) && (rcv[2] == 20);
        end
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b1;
            total++;
            if (rcv[k] != 20 || exq[k].size() != 0) begin
                bad++;
                $display("FAIL stream_count dut%0d: received %0d pending %0d required 20/0", k, rcv[k], exq[k].size());
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] exp_s[3];
        logic [33:0] res;
        exp_s[0] = 32'd17; exp_s[1] = 32'd1; exp_s[2] = 32'd17;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                xd[k] = 32'(2 * s + 1); yd[k] = 32'(2 * s + 2); c0d[k] = 1'b0; subd[k] = 1'b0;
                iv[k] = 1'b1; ordy[k] = 1'b1;
            end
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        for (int k = 0; k < 3; k++) iv[k] = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({ov[k], co[k], of[k], sm[k]} !== 35'd0 || ir[k] !== 1'b1) begin
                bad++;
                $display("FAIL midreset_clear dut%0d: valid=%b sum=%0h in_ready=%b required 0/0/1",
                         k, ov[k], sm[k], ir[k]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (ov[k] !== 1'b0) begin
                    bad++;
                    $display("FAIL stale_result dut%0d cycle%0d: out_valid=%b required 0", k, c, ov[k]);
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            xd[k] = 32'd12; yd[k] = 32'd5; c0d[k] = 1'b0; subd[k] = 1'b0; iv[k] = 1'b1;
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) iv[k] = 1'b0;
        for (int e = 1; e < 6; e++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (e <= lat_of(k) - 1) begin
                    total++;
                    if (ov[k] !== (e == lat_of(k) - 1)) begin
                        bad++;
                        $display("FAIL midreset_latency dut%0d edge+%0d: out_valid=%b required %b",
                                 k, e, ov[k], e == lat_of(k) - 1);
                    end
                end
                if (e == lat_of(k) - 1) begin
                    res = gold(k, 32'd12, 32'd5, 1'b0, 1'b0);
                    total++;
                    if (sm[k] !== exp_s[k] || {of[k], co[k], sm[k]} !== res) begin
                        bad++;
                        $display("FAIL midreset_sum dut%0d: got %0h required %0h", k, sm[k], exp_s[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b1; c0d[k] = 1'b0; subd[k] = 1'b0;
            xd[k] = '0; yd[k] = '0;
        end
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
